// File: rtl/mips_pkg.sv
// Shared types for the control pipeline: control bundle, forwarding selects, stage record.
package mips_pkg;

    // Decoded control bits from ID; field order fixes the 9-bit packing.
    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic [1:0] alu_op;
    } ctrl_t;

    // ALU operand source selects.
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    // Register-address width of the standard core configuration.
    localparam int REG_AW_DEF = 5;

    // One pipeline stage at the standard register-address width.
    typedef struct packed {
        logic                  valid;
        ctrl_t                 ctrl;
        logic [REG_AW_DEF-1:0] rs;
        logic [REG_AW_DEF-1:0] rt;
        logic [REG_AW_DEF-1:0] waddr;
    } stage_t;

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational load-use hazard detection, branch flush and EX operand forwarding.
module hazard_fwd_unit
    import mips_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              id_valid,
    input  logic              id_alu_src,
    input  logic              id_mem_write,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic              ex_branch,
    input  logic [REG_AW-1:0] ex_waddr,
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              ex_zero,
    input  logic              mem_valid,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] mem_waddr,
    input  logic              wb_valid,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_waddr,
    output logic              hz,
    output logic              stall,
    output logic              flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b
);

    logic uses_rt;
    logic taken;
    logic mem_src;
    logic wb_src;

    assign uses_rt = ~id_alu_src | id_mem_write;
    assign taken   = ex_valid & ex_branch & ex_zero;

    // Register 0 is never a producer, so it can neither stall nor forward.
    assign mem_src = mem_valid & mem_reg_write & (mem_waddr != '0);
    assign wb_src  = wb_valid & wb_reg_write & (wb_waddr != '0);

    // Load in EX whose destination is read by ID must wait one cycle.
    always_comb begin
        hz = id_valid & ex_valid & ex_mem_read & (ex_waddr != '0) &
             ((ex_waddr == id_rs) | (uses_rt & (ex_waddr == id_rt)));
    end

    // A taken branch kills the ID instruction, so it must not also stall.
    assign flush = taken;
    assign stall = hz & ~taken;

    // Nearest producer wins: MEM result is newer than WB result.
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (mem_src && mem_waddr == ex_rs)     fwd_a = FWD_MEM;
        else if (wb_src && wb_waddr == ex_rs)  fwd_a = FWD_WB;
        if (mem_src && mem_waddr == ex_rt)     fwd_b = FWD_MEM;
        else if (wb_src && wb_waddr == ex_rt)  fwd_b = FWD_WB;
    end

endmodule

// File: rtl/ctrl_pipeline.sv
// EX/MEM/WB control stage registers with hazard, flush, forwarding and bubble counting.
module ctrl_pipeline
    import mips_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  ctrl_t             id_ctrl,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              ex_zero,
    output logic              stall,
    output logic              flush,
    output ctrl_t             ex_ctrl,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output ctrl_t             mem_ctrl,
    output logic              wb_reg_write,
    output logic              wb_mem_to_reg,
    output logic [REG_AW-1:0] wb_waddr,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              ex_valid, mem_valid, wb_valid;
    ctrl_t             ex_c, mem_c;
    logic [REG_AW-1:0] ex_rs, ex_rt, ex_wa, mem_wa, wb_wa;
    logic              wb_rw, wb_m2r;
    logic              hz, bubble;

    hazard_fwd_unit #(.REG_AW(REG_AW)) u_hfu (
        .id_valid      (id_valid),
        .id_alu_src    (id_ctrl.alu_src),
        .id_mem_write  (id_ctrl.mem_write),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .ex_valid      (ex_valid),
        .ex_mem_read   (ex_c.mem_read),
        .ex_branch     (ex_c.branch),
        .ex_waddr      (ex_wa),
        .ex_rs         (ex_rs),
        .ex_rt         (ex_rt),
        .ex_zero       (ex_zero),
        .mem_valid     (mem_valid),
        .mem_reg_write (mem_c.reg_write),
        .mem_waddr     (mem_wa),
        .wb_valid      (wb_valid),
        .wb_reg_write  (wb_rw),
        .wb_waddr      (wb_wa),
        .hz            (hz),
        .stall         (stall),
        .flush         (flush),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b)
    );

    // Killed, stalled or empty ID slots enter EX as a fully zeroed bubble.
    assign bubble = flush | hz | ~id_valid;

    // EX stage: capture ID or insert a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid <= 1'b0;
            ex_c     <= '0;
            ex_rs    <= '0;
            ex_rt    <= '0;
            ex_wa    <= '0;
        end else if (bubble) begin
            ex_valid <= 1'b0;
            ex_c     <= '0;
            ex_rs    <= '0;
            ex_rt    <= '0;
            ex_wa    <= '0;
        end else begin
            ex_valid <= 1'b1;
            ex_c     <= id_ctrl;
            ex_rs    <= id_rs;
            ex_rt    <= id_rt;
            ex_wa    <= id_ctrl.reg_dst ? id_rd : id_rt;
        end
    end

    // MEM and WB stages advance unconditionally; WB keeps only what it drives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid <= 1'b0;
            mem_c     <= '0;
            mem_wa    <= '0;
            wb_valid  <= 1'b0;
            wb_rw     <= 1'b0;
            wb_m2r    <= 1'b0;
            wb_wa     <= '0;
        end else begin
            mem_valid <= ex_valid;
            mem_c     <= ex_c;
            mem_wa    <= ex_wa;
            wb_valid  <= mem_valid;
            wb_rw     <= mem_c.reg_write;
            wb_m2r    <= mem_c.mem_to_reg;
            wb_wa     <= mem_wa;
        end
    end

    // Count bubble-producing cycles, sticking at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bubble_cnt <= '0;
        else if ((hz | flush) && (bubble_cnt != '1))
            bubble_cnt <= bubble_cnt + 1'b1;
    end

    assign ex_ctrl       = ex_valid  ? ex_c  : '0;
    assign mem_ctrl      = mem_valid ? mem_c : '0;
    assign wb_reg_write  = wb_valid & wb_rw;
    assign wb_mem_to_reg = wb_valid & wb_m2r;
    assign wb_waddr      = wb_wa;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Scoreboard bench: driver pushes model expectations, negedge monitor pops and compares.
module tb_ctrl_pipeline;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0;
    ctrl_t       id_ctrl = '0;
    logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
    logic        ex_zero = 1'b0;

    logic        stall, flush, wb_reg_write, wb_mem_to_reg;
    ctrl_t       ex_ctrl, mem_ctrl;
    logic [1:0]  fwd_a, fwd_b;
    logic [4:0]  wb_waddr;
    logic [15:0] bubble_cnt;

    logic        stall2, flush2, wb_reg_write2, wb_mem_to_reg2;
    ctrl_t       ex_ctrl2, mem_ctrl2;
    logic [1:0]  fwd_a2, fwd_b2;
    logic [4:0]  wb_waddr2;
    logic [1:0]  bubble_cnt2;

    ctrl_pipeline #(.CNT_W(16), .REG_AW(5)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_zero(ex_zero),
        .stall(stall), .flush(flush), .ex_ctrl(ex_ctrl), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .mem_ctrl(mem_ctrl), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
        .wb_waddr(wb_waddr), .bubble_cnt(bubble_cnt)
    );

    ctrl_pipeline #(.CNT_W(2), .REG_AW(5)) dut2 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_zero(ex_zero),
        .stall(stall2), .flush(flush2), .ex_ctrl(ex_ctrl2), .fwd_a(fwd_a2), .fwd_b(fwd_b2),
        .mem_ctrl(mem_ctrl2), .wb_reg_write(wb_reg_write2), .wb_mem_to_reg(wb_mem_to_reg2),
        .wb_waddr(wb_waddr2), .bubble_cnt(bubble_cnt2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        ctrl_t      ctrl;
        logic [4:0] rs, rt, rd;
    } instr_t;

    typedef struct {
        logic        stall, flush;
        ctrl_t       ex_ctrl, mem_ctrl;
        logic [1:0]  fa, fb;
        logic        wre, m2r;
        logic [4:0]  wa;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
    } exp_t;

    int n_chk = 0;
    int n_err = 0;
    exp_t   sb[$];
    instr_t dq[$];

    // Reference model: pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB.
    stage_t pipe[3];
    int     m_cnt;
    bit     held, flushed;
    instr_t cur;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic instr_t nop();
        instr_t i;
        i.valid = 1'b0; i.ctrl = '0; i.rs = '0; i.rt = '0; i.rd = '0;
        return i;
    endfunction

    function automatic instr_t mk(input int kind, input int rs, input int rt, input int rd);
        instr_t i;
        i = nop();
        i.valid = 1'b1;
        i.rs = 5'(rs); i.rt = 5'(rt); i.rd = 5'(rd);
        case (kind)
            0: begin i.ctrl.alu_src = 1; i.ctrl.mem_to_reg = 1; i.ctrl.reg_write = 1; i.ctrl.mem_read = 1; end // lw
            1: begin i.ctrl.reg_dst = 1; i.ctrl.reg_write = 1; i.ctrl.alu_op = 2'b10; end              // R-type
            2: begin i.ctrl.alu_src = 1; i.ctrl.mem_write = 1; end                                     // sw
            3: begin i.ctrl.branch = 1; i.ctrl.alu_op = 2'b01; end                                     // beq
            default: begin i.ctrl.alu_src = 1; i.ctrl.mem_read = 1; i.ctrl.branch = 1; i.ctrl.reg_write = 1; end // load+branch
        endcase
        return i;
    endfunction

    function automatic instr_t rand_instr();
        if ($urandom_range(0, 5) == 0) return nop();
        return mk($urandom_range(0, 4), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
    endfunction

    function automatic logic [1:0] fwd_of(input logic [4:0] src);
        for (int d = 1; d <= 2; d++)
            if (pipe[d].valid && pipe[d].ctrl.reg_write && pipe[d].waddr != 0 && pipe[d].waddr == src)
                return (d == 1) ? FWD_MEM : FWD_WB;
        return FWD_RF;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 3; s++) pipe[s] = '0;
        m_cnt = 0; held = 0; flushed = 0; cur = nop();
    endtask

    // Expected outputs for this cycle, then advance the model one clock.
    task automatic model_step(input instr_t id, input logic z);
        exp_t e;
        logic reads_rt, hz, taken;
        reads_rt = !id.ctrl.alu_src || id.ctrl.mem_write;
        hz = id.valid && pipe[0].valid && pipe[0].ctrl.mem_read && pipe[0].waddr != 0 &&
             (pipe[0].waddr == id.rs || (reads_rt && pipe[0].waddr == id.rt));
        taken = pipe[0].valid && pipe[0].ctrl.branch && z;
        e.stall    = hz && !taken;
        e.flush    = taken;
        e.ex_ctrl  = pipe[0].valid ? pipe[0].ctrl : '0;
        e.mem_ctrl = pipe[1].valid ? pipe[1].ctrl : '0;
        e.fa       = fwd_of(pipe[0].rs);
        e.fb       = fwd_of(pipe[0].rt);
        e.wre      = pipe[2].valid && pipe[2].ctrl.reg_write;
        e.m2r      = pipe[2].valid && pipe[2].ctrl.mem_to_reg;
        e.wa       = pipe[2].waddr;
        e.cnt      = 16'(m_cnt);
        e.cnt2     = 2'((m_cnt > 3) ? 3 : m_cnt);
        sb.push_back(e);
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        if (taken || hz || !id.valid) pipe[0] = '0;
        else begin
            pipe[0].valid = 1'b1;
            pipe[0].ctrl  = id.ctrl;
            pipe[0].rs    = id.rs;
            pipe[0].rt    = id.rt;
            pipe[0].waddr = id.ctrl.reg_dst ? id.rd : id.rt;
        end
        if ((hz || taken) && m_cnt < 65535) m_cnt++;
        held = e.stall;
        flushed = e.flush;
    endtask

    // One clock of stimulus: ID is held on stall, emptied after a flush.
    task automatic cycle(input bit rnd);
        logic z;
        @(posedge clk); #1;
        if (!held) begin
            if (flushed)            cur = nop();
            else if (dq.size() > 0) cur = dq.pop_front();
            else                    cur = rnd ? rand_instr() : nop();
        end
        z = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        id_valid = cur.valid; id_ctrl = cur.ctrl;
        id_rs = cur.rs; id_rt = cur.rt; id_rd = cur.rd; ex_zero = z;
        model_step(cur, z);
    endtask

    task automatic check_reset_outputs();
        chk("rst_stall", 32'(stall), 0);
        chk("rst_flush", 32'(flush), 0);
        chk("rst_ex_ctrl", 32'(ex_ctrl), 0);
        chk("rst_mem_ctrl", 32'(mem_ctrl), 0);
        chk("rst_fwd", 32'({fwd_a, fwd_b}), 0);
        chk("rst_wb", 32'({wb_reg_write, wb_mem_to_reg, wb_waddr}), 0);
        chk("rst_cnt", 32'(bubble_cnt), 0);
        chk("rst_cnt2", 32'(bubble_cnt2), 0);
    endtask

    // Asynchronous reset mid-cycle with the pipe populated.
    task automatic mid_reset();
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1 check_reset_outputs();
        model_reset();
        id_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #2;
        rst_n = 1'b1;
    endtask

    // Monitor: every cycle out of reset the DUT presents a full output set.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && sb.size() > 0) begin
                e = sb.pop_front();
                chk("stall",      32'(stall),         32'(e.stall));
                chk("flush",      32'(flush),         32'(e.flush));
                chk("ex_ctrl",    32'(ex_ctrl),       32'(e.ex_ctrl));
                chk("mem_ctrl",   32'(mem_ctrl),      32'(e.mem_ctrl));
                chk("fwd_a",      32'(fwd_a),         32'(e.fa));
                chk("fwd_b",      32'(fwd_b),         32'(e.fb));
                chk("wb_wr",      32'(wb_reg_write),  32'(e.wre));
                chk("wb_m2r",     32'(wb_mem_to_reg), 32'(e.m2r));
                chk("wb_waddr",   32'(wb_waddr),      32'(e.wa));
                chk("bubble_cnt", 32'(bubble_cnt),    32'(e.cnt));
                chk("cnt_sat",    32'(bubble_cnt2),   32'(e.cnt2));
                chk("stall_w2",   32'(stall2),        32'(e.stall));
            end
        end
    end

    initial begin
        model_reset();
        #1 check_reset_outputs();
        #12 rst_n = 1'b1;

        // lw $8 ; add $9,$8,$2 : one stall, then WB forward on A
        dq.push_back(mk(0, 1, 8, 0));
        dq.push_back(mk(1, 8, 2, 9));
        repeat (3) dq.push_back(nop());
        // add $3 ; sub $4,$3,$3 : MEM forward on both
        dq.push_back(mk(1, 1, 2, 3));
        dq.push_back(mk(1, 3, 3, 4));
        repeat (3) dq.push_back(nop());
        // add $3 ; gap ; sub : WB forward on both
        dq.push_back(mk(1, 1, 2, 3));
        dq.push_back(nop());
        dq.push_back(mk(1, 3, 3, 4));
        repeat (3) dq.push_back(nop());
        // lw $0 ; add rs=$0 : no stall, no forward
        dq.push_back(mk(0, 1, 0, 0));
        dq.push_back(mk(1, 0, 0, 5));
        repeat (3) dq.push_back(nop());
        // lw $8 ; sw rt=$8 : stall because the store reads rt
        dq.push_back(mk(0, 1, 8, 0));
        dq.push_back(mk(2, 1, 8, 0));
        repeat (3) dq.push_back(nop());
        // branch that also loads $8, taken, with dependent add in ID : flush wins
        dq.push_back(mk(4, 1, 8, 0));
        dq.push_back(mk(1, 8, 1, 6));
        repeat (3) dq.push_back(nop());
        // further load-use pairs push the 2-bit counter past saturation
        for (int k = 0; k < 3; k++) begin
            dq.push_back(mk(0, 2, 7, 0));
            dq.push_back(mk(1, 7, 7, 7));
        end
        repeat (4) dq.push_back(nop());

        while (dq.size() > 0) cycle(1'b0);
        repeat (4) cycle(1'b0);

        for (int n = 0; n < 300; n++) cycle(1'b1);
        mid_reset();
        for (int n = 0; n < 300; n++) cycle(1'b1);

        repeat (3) @(negedge clk);
        #1;
        chk("sb_drained", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
